// File: rtl/pong_if.sv
// pong_if: Pong engine bus; master drives frame tick, pixel position, start and paddle buttons, slave returns draw flags, scores, state and winner
interface pong_if #(
  parameter int PIX_W = 10,
  parameter int SCORE_W = 4
);
  logic frame_tick;
  logic [PIX_W-1:0] col;
  logic [PIX_W-1:0] row;
  logic game_start;
  logic up_p1;
  logic dn_p1;
  logic up_p2;
  logic dn_p2;
  logic draw;
  logic draw_ball;
  logic [SCORE_W-1:0] score_p1;
  logic [SCORE_W-1:0] score_p2;
  logic [1:0] state;
  logic game_over;
  logic winner;
  modport master (
    output frame_tick, col, row, game_start, up_p1, dn_p1, up_p2, dn_p2,
    input draw, draw_ball, score_p1, score_p2, state, game_over, winner
  );
  modport slave (
    input frame_tick, col, row, game_start, up_p1, dn_p1, up_p2, dn_p2,
    output draw, draw_ball, score_p1, score_p2, state, game_over, winner
  );
endinterface

// File: rtl/pong_engine.sv
// pong_engine: tile-grid Pong (paddles, ball, scores, match end); ports MAX10_CLK1_50, rst (sync, active-high) and pong_if.slave bus carrying tick/pixel/buttons in and registered draw flags, scores, state, winner out
module pong_engine #(
  parameter int PIX_W = 10,
  parameter int TILE_BITS = 4,
  parameter int BOARD_COLS = 40,
  parameter int BOARD_ROWS = 30,
  parameter int PADDLE_H = 6,
  parameter int BALL_FRAMES = 3,
  parameter int PADDLE_FRAMES = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE = 9,
  parameter int SCORE_W = 4
) (
  input logic MAX10_CLK1_50,
  input logic rst,
  pong_if.slave bus
);
  localparam int XW = $clog2(BOARD_COLS);
  localparam int YW = $clog2(BOARD_ROWS);
  localparam int BW = $clog2(BALL_FRAMES + 1);
  localparam int PW = $clog2(PADDLE_FRAMES + 1);
  localparam int SW = $clog2(SERVE_FRAMES + 1);
  localparam logic [XW-1:0] CX = XW'(BOARD_COLS / 2);
  localparam logic [YW-1:0] CY = YW'(BOARD_ROWS / 2);
  localparam logic [YW-1:0] CT = YW'((BOARD_ROWS - PADDLE_H) / 2);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  typedef enum logic [1:0] {IDLE, RUNNING, POINT, OVER} state_t;
  state_t state, state_n;
  logic [XW-1:0] bx, bx_n, bx_step;
  logic [YW-1:0] by, by_n, by_step, t1, t1_n, t1_mv, t2, t2_n, t2_mv;
  logic dx_neg, dx_neg_n, dy_neg, dy_neg_n, winner, winner_n;
  logic [SCORE_W-1:0] s1, s1_n, s1_inc, s2, s2_n, s2_inc;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [SW-1:0] scnt, scnt_n;
  logic b_wrap, p_wrap, s_wrap, bounce, dy_new, at_l, at_r, miss_l, miss_r, dx_new, won;
  logic [PIX_W-1:0] tc, tr;
  logic on_board, ball_px, pad_px, draw, draw_ball;
  function automatic logic covers(logic [YW-1:0] top, logic [YW-1:0] y);
    return y >= top && {1'b0, y} < {1'b0, top} + (YW+1)'(PADDLE_H);
  endfunction
  function automatic logic [YW-1:0] paddle_mv(logic [YW-1:0] top, logic up, logic dn);
    return (up && !dn && top != '0) ? top - 1'b1 :
           (dn && !up && {1'b0, top} + (YW+1)'(PADDLE_H) < (YW+1)'(BOARD_ROWS)) ? top + 1'b1 : top;
  endfunction
  function automatic logic px_covers(logic [PIX_W-1:0] r, logic [YW-1:0] top);
    return r >= PIX_W'(top) && r < PIX_W'(top) + PIX_W'(PADDLE_H);
  endfunction
  always_comb begin
    b_wrap = bus.frame_tick && bcnt == BW'(BALL_FRAMES - 1);
    p_wrap = bus.frame_tick && pcnt == PW'(PADDLE_FRAMES - 1);
    s_wrap = bus.frame_tick && scnt == SW'(SERVE_FRAMES - 1);
    // after a wall bounce the ball moves one tile in the reflected direction
    bounce = dy_neg ? by == '0 : by == YW'(BOARD_ROWS - 1);
    dy_new = dy_neg ^ bounce;
    by_step = dy_new ? by - 1'b1 : by + 1'b1;
    // paddle hit test uses the row before this step's vertical move
    at_l = dx_neg && bx == XW'(1);
    at_r = !dx_neg && bx == XW'(BOARD_COLS - 2);
    miss_l = at_l && !covers(t1, by);
    miss_r = at_r && !covers(t2, by);
    dx_new = dx_neg ^ (at_l || at_r);
    bx_step = dx_new ? bx - 1'b1 : bx + 1'b1;
    t1_mv = p_wrap ? paddle_mv(t1, bus.up_p1, bus.dn_p1) : t1;
    t2_mv = p_wrap ? paddle_mv(t2, bus.up_p2, bus.dn_p2) : t2;
    s1_inc = s1 == WIN ? s1 : s1 + 1'b1;
    s2_inc = s2 == WIN ? s2 : s2 + 1'b1;
    won = (miss_r ? s1_inc : s2_inc) == WIN;
  end
  always_comb begin
    state_n = state;
    bx_n = bx;
    by_n = by;
    dx_neg_n = dx_neg;
    dy_neg_n = dy_neg;
    t1_n = t1;
    t2_n = t2;
    s1_n = s1;
    s2_n = s2;
    winner_n = winner;
    bcnt_n = bcnt;
    pcnt_n = pcnt;
    scnt_n = scnt;
    case (state)
      IDLE: if (bus.game_start) begin
        state_n = RUNNING;
        bcnt_n = '0;
        pcnt_n = '0;
      end
      RUNNING: if (bus.frame_tick) begin
        bcnt_n = b_wrap ? '0 : bcnt + 1'b1;
        pcnt_n = p_wrap ? '0 : pcnt + 1'b1;
        if (b_wrap && (miss_l || miss_r)) begin
          // serve toward the player who conceded; dy is kept as it was
          bx_n = CX;
          by_n = CY;
          dx_neg_n = miss_l;
          s1_n = miss_r ? s1_inc : s1;
          s2_n = miss_l ? s2_inc : s2;
          scnt_n = '0;
          state_n = won ? OVER : POINT;
          winner_n = won ? miss_l : winner;
        end else begin
          t1_n = t1_mv;
          t2_n = t2_mv;
          bx_n = b_wrap ? bx_step : bx;
          by_n = b_wrap ? by_step : by;
          dx_neg_n = b_wrap ? dx_new : dx_neg;
          dy_neg_n = b_wrap ? dy_new : dy_neg;
        end
      end
      POINT: if (bus.frame_tick) begin
        pcnt_n = p_wrap ? '0 : pcnt + 1'b1;
        t1_n = t1_mv;
        t2_n = t2_mv;
        scnt_n = s_wrap ? '0 : scnt + 1'b1;
        state_n = s_wrap ? RUNNING : POINT;
      end
      OVER: if (bus.game_start) begin
        state_n = RUNNING;
        s1_n = '0;
        s2_n = '0;
        winner_n = 1'b0;
        bx_n = CX;
        by_n = CY;
        t1_n = CT;
        t2_n = CT;
        bcnt_n = '0;
        pcnt_n = '0;
        scnt_n = '0;
      end
    endcase
  end
  always_comb begin
    tc = bus.col >> TILE_BITS;
    tr = bus.row >> TILE_BITS;
    on_board = tc < PIX_W'(BOARD_COLS) && tr < PIX_W'(BOARD_ROWS);
    ball_px = on_board && tc == PIX_W'(bx) && tr == PIX_W'(by);
    pad_px = on_board && ((tc == '0 && px_covers(tr, t1)) ||
             (tc == PIX_W'(BOARD_COLS - 1) && px_covers(tr, t2)));
  end
  always_ff @(posedge MAX10_CLK1_50) begin
    if (rst) begin
      state <= IDLE;
      bx <= CX;
      by <= CY;
      dx_neg <= 1'b0;
      dy_neg <= 1'b0;
      t1 <= CT;
      t2 <= CT;
      s1 <= '0;
      s2 <= '0;
      winner <= 1'b0;
      bcnt <= '0;
      pcnt <= '0;
      scnt <= '0;
      draw <= 1'b0;
      draw_ball <= 1'b0;
    end else begin
      state <= state_n;
      bx <= bx_n;
      by <= by_n;
      dx_neg <= dx_neg_n;
      dy_neg <= dy_neg_n;
      t1 <= t1_n;
      t2 <= t2_n;
      s1 <= s1_n;
      s2 <= s2_n;
      winner <= winner_n;
      bcnt <= bcnt_n;
      pcnt <= pcnt_n;
      scnt <= scnt_n;
      draw <= ball_px || pad_px;
      draw_ball <= ball_px;
    end
  end
  assign bus.draw = draw;
  assign bus.draw_ball = draw_ball;
  assign bus.score_p1 = s1;
  assign bus.score_p2 = s2;
  assign bus.state = state;
  assign bus.game_over = state == OVER;
  assign bus.winner = winner;
endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: pixel-probe tables, hand sequences and random play checked against a game-rule model
module tb_pong_engine;
  localparam int COLS = 40, ROWS = 30, H = 6, BF = 3, PF = 2, SF = 60, WIN = 9;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pong_if #(.PIX_W(10), .SCORE_W(4)) bus ();
  pong_engine dut (.MAX10_CLK1_50(clk), .rst(rst), .bus(bus));
  int vectors = 0, miscompares = 0;
  int m_st, m_bx, m_by, m_dx, m_dy, m_t1, m_t2, m_s1, m_s2, m_win, m_bc, m_pc, m_sc;
  typedef struct { int col; int row; int draw; int ball; } vec_t;
  vec_t tbl[14];
  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      if (miscompares <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic model_reset();
    m_st = 0; m_bx = COLS / 2; m_by = ROWS / 2; m_dx = 1; m_dy = 1;
    m_t1 = (ROWS - H) / 2; m_t2 = (ROWS - H) / 2;
    m_s1 = 0; m_s2 = 0; m_win = 0; m_bc = 0; m_pc = 0; m_sc = 0;
  endtask
  function automatic int pad_move(int t, logic up, logic dn);
    int n = t + int'(dn) - int'(up);
    return n < 0 ? 0 : (n > ROWS - H ? ROWS - H : n);
  endfunction
  task automatic move_paddles();
    m_t1 = pad_move(m_t1, bus.up_p1, bus.dn_p1);
    m_t2 = pad_move(m_t2, bus.up_p2, bus.dn_p2);
  endtask
  task automatic model_update();
    int nx, ny, ndx, ndy, who;
    bit pw, bw;
    if (rst) begin
      model_reset();
      return;
    end
    case (m_st)
      0: if (bus.game_start) begin m_st = 1; m_bc = 0; m_pc = 0; end
      1: if (bus.frame_tick) begin
        m_pc++; pw = m_pc == PF; if (pw) m_pc = 0;
        m_bc++; bw = m_bc == BF; if (bw) m_bc = 0;
        who = 0;
        if (bw) begin
          ndy = m_dy; ny = m_by + ndy;
          if (ny < 0 || ny >= ROWS) begin ndy = -ndy; ny = m_by + ndy; end
          ndx = m_dx; nx = m_bx + ndx;
          if (nx == 0) begin
            if (m_by >= m_t1 && m_by < m_t1 + H) begin ndx = 1; nx = 2; end else who = 2;
          end else if (nx == COLS - 1) begin
            if (m_by >= m_t2 && m_by < m_t2 + H) begin ndx = -1; nx = COLS - 3; end else who = 1;
          end
          if (who == 0) begin m_bx = nx; m_by = ny; m_dx = ndx; m_dy = ndy; end
        end
        if (who != 0) begin
          if (who == 1) m_s1 = m_s1 + 1 > WIN ? WIN : m_s1 + 1;
          else m_s2 = m_s2 + 1 > WIN ? WIN : m_s2 + 1;
          m_bx = COLS / 2; m_by = ROWS / 2; m_dx = who == 1 ? 1 : -1;
          if ((who == 1 ? m_s1 : m_s2) == WIN) begin m_st = 3; m_win = who - 1; end
          else begin m_st = 2; m_sc = 0; end
        end else if (pw) move_paddles();
      end
      2: if (bus.frame_tick) begin
        m_pc++;
        if (m_pc == PF) begin m_pc = 0; move_paddles(); end
        m_sc++;
        if (m_sc == SF) begin m_sc = 0; m_st = 1; end
      end
      default: if (bus.game_start) begin
        m_st = 1; m_s1 = 0; m_s2 = 0; m_win = 0;
        m_bx = COLS / 2; m_by = ROWS / 2;
        m_t1 = (ROWS - H) / 2; m_t2 = (ROWS - H) / 2;
        m_bc = 0; m_pc = 0; m_sc = 0;
      end
    endcase
  endtask
  task automatic model_draw(input logic [9:0] c, input logic [9:0] r, output int d, output int b);
    int tc, tr;
    bit pad, on;
    tc = int'(c) / 16;
    tr = int'(r) / 16;
    on = tc < COLS && tr < ROWS;
    b = (on && tc == m_bx && tr == m_by) ? 1 : 0;
    pad = (tc == 0 && tr >= m_t1 && tr < m_t1 + H) || (tc == COLS - 1 && tr >= m_t2 && tr < m_t2 + H);
    d = (b == 1 || (on && pad)) ? 1 : 0;
  endtask
  task automatic cyc();
    int ed, eb;
    model_draw(bus.col, bus.row, ed, eb);
    @(posedge clk);
    if (rst) begin ed = 0; eb = 0; end
    model_update();
    #1;
    chk("draw", int'(bus.draw), ed);
    chk("draw_ball", int'(bus.draw_ball), eb);
    chk("state", int'(bus.state), m_st);
    chk("score_p1", int'(bus.score_p1), m_s1);
    chk("score_p2", int'(bus.score_p2), m_s2);
    chk("game_over", int'(bus.game_over), m_st == 3 ? 1 : 0);
    chk("winner", int'(bus.winner), m_win);
  endtask
  task automatic rand_pix();
    int tc, tr;
    case ($urandom_range(3))
      0: begin tc = m_bx + int'($urandom_range(2)) - 1; tr = m_by + int'($urandom_range(2)) - 1; end
      1: begin tc = 0; tr = int'($urandom_range(ROWS - 1)); end
      2: begin tc = COLS - 1; tr = int'($urandom_range(ROWS - 1)); end
      default: begin tc = int'($urandom_range(63)); tr = int'($urandom_range(63)); end
    endcase
    bus.col = 10'(((tc & 63) << 4) + int'($urandom_range(15)));
    bus.row = 10'(((tr & 63) << 4) + int'($urandom_range(15)));
  endtask
  task automatic tickn(int n);
    for (int i = 0; i < n; i++) begin
      rand_pix(); bus.frame_tick = 1'b1; cyc(); bus.frame_tick = 1'b0;
      rand_pix(); cyc();
      rand_pix(); cyc();
    end
  endtask
  task automatic probe(string name, int tc, int tr, int ed, int eb);
    bus.col = 10'(tc * 16 + 8);
    bus.row = 10'(tr * 16 + 8);
    cyc();
    chk({name, "_draw"}, int'(bus.draw), ed);
    chk({name, "_ball"}, int'(bus.draw_ball), eb);
  endtask
  task automatic pulse_start();
    bus.game_start = 1'b1; cyc(); bus.game_start = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask
  initial begin
    tbl = '{'{5, 200, 1, 0}, '{640, 0, 0, 0}, '{320, 240, 1, 1}, '{335, 255, 1, 1},
            '{319, 240, 0, 0}, '{320, 256, 0, 0}, '{0, 191, 0, 0}, '{15, 287, 1, 0},
            '{0, 288, 0, 0}, '{624, 192, 1, 0}, '{639, 479, 0, 0}, '{700, 200, 0, 0},
            '{5, 500, 0, 0}, '{1023, 1023, 0, 0}};
    bus.frame_tick = 1'b0; bus.game_start = 1'b0;
    bus.up_p1 = 1'b0; bus.dn_p1 = 1'b0; bus.up_p2 = 1'b0; bus.dn_p2 = 1'b0;
    bus.col = 10'd5; bus.row = 10'd200;
    model_reset();
    rst = 1'b1; cyc(); cyc();
    chk("rst_draw", int'(bus.draw), 0);
    chk("rst_state", int'(bus.state), 0);
    rst = 1'b0;
    foreach (tbl[i]) begin
      bus.col = 10'(tbl[i].col); bus.row = 10'(tbl[i].row); cyc();
      chk("tbl_draw", int'(bus.draw), tbl[i].draw);
      chk("tbl_ball", int'(bus.draw_ball), tbl[i].ball);
    end
    tickn(10);
    chk("idle_state", int'(bus.state), 0);
    probe("idle_ball", 20, 15, 1, 1);
    probe("idle_p1top", 0, 12, 1, 0);
    probe("idle_p1above", 0, 11, 0, 0);
    probe("idle_p2bot", 39, 17, 1, 0);
    probe("idle_p2below", 39, 18, 0, 0);
    pulse_start();
    chk("start_state", int'(bus.state), 1);
    tickn(2);
    probe("tick2_ball", 20, 15, 1, 1);
    tickn(1);
    probe("step1_ball", 21, 16, 1, 1);
    tickn(39);
    probe("step14_ball", 34, 29, 1, 1);
    tickn(3);
    probe("step15_ball", 35, 28, 1, 1);
    tickn(12);
    chk("miss_score_p1", int'(bus.score_p1), 1);
    chk("miss_state", int'(bus.state), 2);
    probe("serve_ball", 20, 15, 1, 1);
    tickn(59);
    chk("serve_wait", int'(bus.state), 2);
    tickn(1);
    chk("serve_done", int'(bus.state), 1);
    tickn(3);
    probe("serve_step", 21, 14, 1, 1);
    bus.up_p2 = 1'b1;
    tickn(24);
    probe("p2_top0", 39, 0, 1, 0);
    probe("p2_row6", 39, 6, 0, 0);
    tickn(10);
    probe("p2_stay0", 39, 0, 1, 0);
    bus.dn_p2 = 1'b1;
    tickn(10);
    probe("p2_updn", 39, 0, 1, 0);
    probe("p2_updn_row6", 39, 6, 0, 0);
    bus.up_p2 = 1'b0;
    tickn(60);
    probe("p2_bottom", 39, 29, 1, 0);
    probe("p2_top24", 39, 24, 1, 0);
    probe("p2_row23", 39, 23, 0, 0);
    bus.dn_p2 = 1'b0;
    do_reset();
    pulse_start();
    bus.dn_p2 = 1'b1;
    tickn(57);
    probe("hit_ball", 37, 24, 1, 1);
    chk("hit_score_p1", int'(bus.score_p1), 0);
    chk("hit_state", int'(bus.state), 1);
    bus.dn_p2 = 1'b0;
    tickn(3);
    probe("hit_next", 36, 23, 1, 1);
    do_reset();
    pulse_start();
    for (int i = 0; i < 1200 && m_st != 3; i++) tickn(1);
    chk("over_state", int'(bus.state), 3);
    chk("over_flag", int'(bus.game_over), 1);
    chk("over_winner", int'(bus.winner), 0);
    chk("over_p1", int'(bus.score_p1), 9);
    chk("over_p2", int'(bus.score_p2), 0);
    tickn(5);
    chk("over_frozen", int'(bus.state), 3);
    probe("over_ball", 20, 15, 1, 1);
    bus.game_start = 1'b1; bus.frame_tick = 1'b1; cyc();
    bus.game_start = 1'b0; bus.frame_tick = 1'b0;
    chk("restart_state", int'(bus.state), 1);
    chk("restart_p1", int'(bus.score_p1), 0);
    chk("restart_winner", int'(bus.winner), 0);
    tickn(4);
    bus.col = 10'd5; bus.row = 10'd200;
    do_reset();
    chk("midrst_state", int'(bus.state), 0);
    chk("midrst_draw", int'(bus.draw), 0);
    probe("midrst_ball", 20, 15, 1, 1);
    probe("midrst_p1top", 0, 12, 1, 0);
    pulse_start();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) begin
        bus.up_p1 = 1'($urandom_range(1)); bus.dn_p1 = 1'($urandom_range(1));
        bus.up_p2 = 1'($urandom_range(1)); bus.dn_p2 = 1'($urandom_range(1));
      end
      bus.frame_tick = $urandom_range(2) == 0;
      bus.game_start = $urandom_range(40) == 0;
      rst = $urandom_range(1500) == 0;
      rand_pix();
      cyc();
    end
    rst = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
